arm_mem_arbiter: RTL and testbench
==================================

// Module: arm_mem_arbiter
// PURPOSE
//  Shares one single-port, fixed-latency memory between the IF stage (instruction fetch, read-only)
//  and the MEM stage (data load/store) of the ARM pipeline under ARM_TOP.
//  Grants one requester at a time, latches its request, and sequences the memory port through a wait-state count.
//  Returns read data with a one-cycle ready pulse, and raises freeze to stall the pipeline while any request is pending.
// PARAMETERS
//  ADDR_W   32  address width, both requesters and memory
//  DATA_W   32  data width
//  MEM_LAT  2   memory wait cycles, >=1; 0 is illegal and must stop elaboration with an error
// PORTS
//  clk        in   1       single clock, rising edge
//  rst        in   1       synchronous, active-low reset (rst==0 resets on the clk edge)
//  if_req     in   1       fetch request, held until if_ready
//  if_addr    in   ADDR_W  fetch address
//  if_rdata   out  DATA_W  fetched instruction, valid while if_ready=1
//  if_ready   out  1       one-cycle completion pulse for fetch
//  dm_req     in   1       data request, held until dm_ready
//  dm_we      in   1       1 = store, 0 = load
//  dm_addr    in   ADDR_W  data address
//  dm_wdata   in   DATA_W  store data
//  dm_rdata   out  DATA_W  load data, valid while dm_ready=1
//  dm_ready   out  1       one-cycle completion pulse for data
//  mem_en     out  1       memory access active
//  mem_we     out  1       memory write strobe, asserted only together with mem_en
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  DATA_W  memory write data
//  mem_rdata  in   DATA_W  memory read data, valid MEM_LAT cycles after mem_en rises
//  freeze     out  1       pipeline stall = (if_req&~if_ready)|(dm_req&~dm_ready), combinational
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0; all registered outputs 0 (mem_*, *_rdata, *_ready). freeze follows its inputs.
//  All mem_*, *_rdata and *_ready outputs are registered.
//  FSM:
//   IDLE: if any req at edge: grant, latch addr/we/wdata/id, mem_en<=1, mem_we<=latched we, cnt<=MEM_LAT-1, go BUSY.
//         Otherwise stay in IDLE.
//   BUSY: cnt!=0 -> cnt<=cnt-1. cnt==0 -> capture mem_rdata into granted *_rdata; clear mem_en/mem_we;
//         granted *_ready<=1; go RESP.
//   RESP: *_ready<=0; go IDLE. No grant is made in RESP.
//  Latency: req first high in cycle 0 (state IDLE) -> mem_en high in cycles 1..MEM_LAT -> *_ready high in cycle MEM_LAT+1.
//   Back-to-back spacing is MEM_LAT+2 cycles.
//  Requests are sampled only in IDLE. The requester drops req, or presents the next one, at the edge that ends its ready cycle.
//  Request fields are latched at grant; later changes to them are ignored.
//  A requester dropping req mid-access: the access still completes and the ready pulse is still issued.
//  Stores: dm_rdata is left unchanged; dm_ready pulses with the same timing as a load.
//  Both ready outputs are never high in the same cycle.
//  Simultaneous if_req & dm_req in IDLE: dm wins (fixed priority; the older instruction goes first). The loser stays pending.
//  Reset mid-access: return to IDLE at once with outputs cleared. The in-flight access is abandoned with no ready pulse.
//   A store already strobed may have written memory.
//  cnt width = $clog2(MEM_LAT+1); it never wraps below 0.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined: on a simultaneous request, grant the requester NOT granted last.
//   The last-grant flag is reset to IF, so dm wins the first tie. Single requests are unaffected.
//  ARB_ROUND_ROBIN_EN undefined: fixed dm priority as above; no last-grant register exists.
// STRUCTURE
//  arm_mem_defs.vh: state encodings IDLE=2'd0, BUSY=2'd1, RESP=2'd2; requester ids ID_IF=1'b0, ID_DM=1'b1.
//  Sub-module arm_arb_pick: combinational winner select from (if_req, dm_req, last_id);
//   contains the ARB_ROUND_ROBIN_EN variant.
//  Top module holds the FSM, counter, latches and output registers.
// TESTING
//  1 Fetch read, MEM_LAT=2, if_addr=0x10, mem returns 0xE3A01005
//    -> mem_en high in cycles 1-2, if_ready high in cycle 3, if_rdata=0xE3A01005.
//  2 Store dm_addr=0x40, dm_wdata=0xDEADBEEF
//    -> mem_we=mem_en=1 for 2 cycles with mem_wdata=0xDEADBEEF; dm_ready in cycle 3; dm_rdata unchanged.
//  3 if_req & dm_req together
//    -> dm served first (ready in cycle 3), IF granted in cycle 4, if_ready in cycle 7; freeze=1 in cycles 0-6.
//  4 Repeated ties under ARB_ROUND_ROBIN_EN
//    -> grant order DM, IF, DM, IF; without the macro, DM is granted every time dm_req is high.
//  5 rst=0 in cycle 2 of a load
//    -> next cycle: state IDLE, mem_en=0, no ready pulse; a new if_req after reset completes normally.
//  6 Sweep MEM_LAT=1 and MEM_LAT=4 -> ready in cycle MEM_LAT+1 in both cases.

Source files
------------

// File: rtl/arm_mem_arbiter_pkg.sv
// rtl/arm_mem_arbiter_pkg.sv - shared types and defaults for the IF/MEM memory arbiter
package arm_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    ID_IF = 1'b0,
    ID_DM = 1'b1
  } req_id_e;

  localparam int unsigned ADDR_W_DEF  = 32;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned MEM_LAT_DEF = 2;

endpackage

// File: rtl/arm_mem_arbiter_if.sv
// rtl/arm_mem_arbiter_if.sv - requester, memory and stall signals of the arbiter
interface arm_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ready;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              freeze;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_ready, dm_rdata, dm_ready, mem_en, mem_we, mem_addr, mem_wdata, freeze
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_ready, dm_rdata, dm_ready, mem_en, mem_we, mem_addr, mem_wdata, freeze
  );
endinterface

// File: rtl/arm_mem_arbiter_pick.sv
// rtl/arm_mem_arbiter_pick.sv - winner select; ARB_ROUND_ROBIN_EN alternates ties, else data side wins
module arm_arb_pick
  import arm_mem_arbiter_pkg::*;
(
  input  logic    if_req_i,
  input  logic    dm_req_i,
`ifdef ARB_ROUND_ROBIN_EN
  input  req_id_e last_id_i,
`endif
  output logic    grant_valid_o,
  output req_id_e grant_id_o
);

  assign grant_valid_o = if_req_i | dm_req_i;

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    grant_id_o = ID_IF;
    if (if_req_i && dm_req_i) begin
      grant_id_o = (last_id_i == ID_DM) ? ID_IF : ID_DM;
    end else if (dm_req_i) begin
      grant_id_o = ID_DM;
    end
  end
`else
  // The data access belongs to the older instruction, so it goes first.
  assign grant_id_o = dm_req_i ? ID_DM : ID_IF;
`endif

endmodule

// File: rtl/arm_mem_arbiter.sv
// rtl/arm_mem_arbiter.sv - shares one fixed-latency memory port between fetch and data; ARB_ROUND_ROBIN_EN selects tie policy
module arm_mem_arbiter
  import arm_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MEM_LAT = MEM_LAT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  arm_mem_arbiter_if.slave bus
);

  if (MEM_LAT < 1) begin : g_bad_lat
    $error("arm_mem_arbiter: MEM_LAT must be at least 1");
  end

  localparam int CNT_W = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  req_id_e           id_q, id_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_ready_q, if_ready_d;
  logic              dm_ready_q, dm_ready_d;
  logic              grant_valid;
  req_id_e           grant_id;

`ifdef ARB_ROUND_ROBIN_EN
  req_id_e last_id_q, last_id_d;
`endif

  arm_arb_pick u_pick (
    .if_req_i      (bus.if_req),
    .dm_req_i      (bus.dm_req),
`ifdef ARB_ROUND_ROBIN_EN
    .last_id_i     (last_id_q),
`endif
    .grant_valid_o (grant_valid),
    .grant_id_o    (grant_id)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    id_d        = id_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ready_d  = if_ready_q;
    dm_ready_d  = dm_ready_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_id_d   = last_id_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          id_d     = grant_id;
          mem_en_d = 1'b1;
          cnt_d    = CNT_LOAD;
          state_d  = BUSY;
`ifdef ARB_ROUND_ROBIN_EN
          last_id_d = grant_id;
`endif
          if (grant_id == ID_DM) begin
            mem_we_d    = bus.dm_we;
            mem_addr_d  = bus.dm_addr;
            mem_wdata_d = bus.dm_wdata;
          end else begin
            mem_we_d   = 1'b0;
            mem_addr_d = bus.if_addr;
          end
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          state_d  = RESP;
          if (id_q == ID_DM) begin
            // A store leaves the last load result visible on dm_rdata.
            if (!mem_we_q) dm_rdata_d = bus.mem_rdata;
            dm_ready_d = 1'b1;
          end else begin
            if_rdata_d = bus.mem_rdata;
            if_ready_d = 1'b1;
          end
        end
      end
      RESP: begin
        if_ready_d = 1'b0;
        dm_ready_d = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      id_q        <= ID_IF;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_id_q   <= ID_IF;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      id_q        <= id_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_id_q   <= last_id_d;
`endif
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.dm_ready  = dm_ready_q;
  assign bus.freeze    = (bus.if_req & ~if_ready_q) | (bus.dm_req & ~dm_ready_q);

endmodule

// File: tb/tb_arm_mem_arbiter.sv
// tb/tb_arm_mem_arbiter.sv - directed vectors for arm_mem_arbiter at MEM_LAT 2, plus 1 and 4
module tb_arm_mem_arbiter;
  import arm_mem_arbiter_pkg::*;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  arm_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus  ();
  arm_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
  arm_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus4 ();

  arm_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut  (.clk(clk), .rst(rst), .bus(bus.slave));
  arm_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1))   u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  arm_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(4))   u_dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

  // Memory model: read data is only valid in the MEM_LAT-th cycle of mem_en.
  logic [31:0] mem [0:63];
  int en_cnt, en1_cnt, en4_cnt;
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[4] <= 32'hE3A01005;
      mem[5] <= 32'h12345678;
    end else if (bus.mem_en && bus.mem_we) begin
      mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end
    en_cnt  <= bus.mem_en  ? en_cnt + 1  : 0;
    en1_cnt <= bus1.mem_en ? en1_cnt + 1 : 0;
    en4_cnt <= bus4.mem_en ? en4_cnt + 1 : 0;
  end
  assign bus.mem_rdata  = (bus.mem_en && en_cnt == LAT - 1) ? mem[bus.mem_addr[7:2]] : 32'hBAD0BAD0;
  assign bus1.mem_rdata = (bus1.mem_en && en1_cnt == 0) ? 32'h11110001 : 32'hBAD0BAD0;
  assign bus4.mem_rdata = (bus4.mem_en && en4_cnt == 3) ? 32'h44440004 : 32'hBAD0BAD0;

  logic sw_req [2];
  assign bus1.if_req = sw_req[0];
  assign bus4.if_req = sw_req[1];
  assign bus1.if_addr = 32'h20;
  assign bus4.if_addr = 32'h20;
  assign bus1.dm_req = 1'b0;
  assign bus4.dm_req = 1'b0;
  assign bus1.dm_we = 1'b0;
  assign bus4.dm_we = 1'b0;
  assign bus1.dm_addr = 32'h0;
  assign bus4.dm_addr = 32'h0;
  assign bus1.dm_wdata = 32'h0;
  assign bus4.dm_wdata = 32'h0;

  typedef struct {
    logic        ifr;
    logic        dmr;
    logic        we;
    logic [31:0] ia;
    logic [31:0] da;
    logic [31:0] wd;
    logic [31:0] exp_if_d;
    logic [31:0] exp_dm_d;
  } vec_t;

  vec_t    vecs [7];
  int      n_tests = 0;
  int      n_fail  = 0;
  req_id_e last_grant;
  logic    rr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    last_grant = ID_IF;
  endtask

  // Cycle 0 is the current cycle; each requester holds req until its ready cycle.
  task automatic run_vec(input int idx, input vec_t v);
    int          if_c, dm_c, en_cycles, we_cycles, bad_freeze, bad_addr, bad_wd;
    logic [31:0] if_d, dm_d, first_a, second_a;
    logic        dm_first, both;
    if_c = -1; dm_c = -1; en_cycles = 0; we_cycles = 0;
    bad_freeze = 0; bad_addr = 0; bad_wd = 0; both = 1'b0;
    if_d = 'x; dm_d = 'x;
    dm_first = v.dmr && !(v.ifr && rr && last_grant == ID_DM);
    first_a  = dm_first ? v.da : v.ia;
    second_a = dm_first ? v.ia : v.da;
    bus.if_req = v.ifr; bus.if_addr = v.ia;
    bus.dm_req = v.dmr; bus.dm_we = v.we; bus.dm_addr = v.da; bus.dm_wdata = v.wd;
    #1;
    chk($sformatf("vec%0d freeze c0", idx), {31'b0, bus.freeze}, {31'b0, v.ifr | v.dmr});
    for (int c = 1; c <= 20 && ((v.ifr && if_c < 0) || (v.dmr && dm_c < 0)); c++) begin
      step();
      if (if_c == c - 1) bus.if_req = 1'b0;
      if (dm_c == c - 1) bus.dm_req = 1'b0;
      #1;
      if (bus.mem_en) begin
        en_cycles++;
        if (bus.mem_addr !== ((c <= LAT) ? first_a : second_a)) bad_addr++;
      end
      if (bus.mem_we) begin
        we_cycles++;
        if (bus.mem_wdata !== v.wd) bad_wd++;
      end
      if (bus.if_ready) begin if_c = c; if_d = bus.if_rdata; end
      if (bus.dm_ready) begin dm_c = c; dm_d = bus.dm_rdata; end
      if (bus.if_ready && bus.dm_ready) both = 1'b1;
      if (bus.freeze !== ((v.ifr && if_c < 0) || (v.dmr && dm_c < 0))) bad_freeze++;
    end
    step();
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    if (v.ifr) begin
      chk($sformatf("vec%0d if_ready cycle", idx), if_c, (v.dmr && dm_first) ? 2 * LAT + 3 : LAT + 1);
      chk($sformatf("vec%0d if_rdata", idx), if_d, v.exp_if_d);
    end
    if (v.dmr) begin
      chk($sformatf("vec%0d dm_ready cycle", idx), dm_c, dm_first ? LAT + 1 : 2 * LAT + 3);
      chk($sformatf("vec%0d dm_rdata", idx), dm_d, v.exp_dm_d);
    end
    chk($sformatf("vec%0d mem_en cycles", idx), en_cycles, LAT * (int'(v.ifr) + int'(v.dmr)));
    chk($sformatf("vec%0d mem_we cycles", idx), we_cycles, (v.dmr && v.we) ? LAT : 0);
    chk($sformatf("vec%0d mem_addr errs", idx), bad_addr, 0);
    chk($sformatf("vec%0d mem_wdata errs", idx), bad_wd, 0);
    chk($sformatf("vec%0d freeze errs", idx), bad_freeze, 0);
    chk($sformatf("vec%0d both ready", idx), {31'b0, both}, 32'd0);
    if (v.ifr && v.dmr) last_grant = dm_first ? ID_IF : ID_DM;
    else if (v.dmr) last_grant = ID_DM;
    else if (v.ifr) last_grant = ID_IF;
  endtask

  initial begin
`ifdef ARB_ROUND_ROBIN_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h10, 32'h00, 32'h0,        32'hE3A01005, 32'h0};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 32'h00, 32'h40, 32'hDEADBEEF, 32'h0,        32'h0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h00, 32'h40, 32'h0,        32'h0,        32'hDEADBEEF};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h00, 32'h44, 32'h0BADF00D, 32'h0,        32'hDEADBEEF};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h14, 32'h44, 32'h0,        32'h12345678, 32'h0BADF00D};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 32'h10, 32'h48, 32'hCAFEF00D, 32'hE3A01005, 32'h0BADF00D};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 32'h00, 32'h48, 32'h0,        32'h0,        32'hCAFEF00D};

    sw_req[0] = 1'b0; sw_req[1] = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
    rst = 1'b0;
    step();
    step();
    chk("reset mem_en",   {31'b0, bus.mem_en},   32'd0);
    chk("reset mem_we",   {31'b0, bus.mem_we},   32'd0);
    chk("reset mem_addr", bus.mem_addr,          32'd0);
    chk("reset mem_wdata", bus.mem_wdata,        32'd0);
    chk("reset rdata",    bus.if_rdata | bus.dm_rdata, 32'd0);
    chk("reset ready",    {30'b0, bus.if_ready, bus.dm_ready}, 32'd0);
    chk("reset freeze",   {31'b0, bus.freeze},   32'd0);
    rst = 1'b1;
    step();
    last_grant = ID_IF;

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Continuous ties: ready every MEM_LAT+2 cycles, order depends on the tie policy.
    begin
      int      rc [4];
      req_id_e rid [4];
      int      n;
      n = 0;
      reset_dut();
      bus.if_req = 1'b1; bus.if_addr = 32'h10;
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h40;
      for (int c = 1; c <= 4 * (LAT + 2); c++) begin
        step();
        if ((bus.if_ready || bus.dm_ready) && n < 4) begin
          rc[n]  = c;
          rid[n] = bus.dm_ready ? ID_DM : ID_IF;
          n++;
        end
      end
      chk("tie ready count", n, 4);
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("tie%0d cycle", i), rc[i], LAT + 1 + i * (LAT + 2));
        chk($sformatf("tie%0d id", i), {31'b0, rid[i]}, {31'b0, (rr && i[0]) ? ID_IF : ID_DM});
      end
      bus.if_req = 1'b0;
      bus.dm_req = 1'b0;
    end

    // Reset during a load abandons it without a ready pulse.
    reset_dut();
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h10;
    step();
    chk("abort mem_en c1", {31'b0, bus.mem_en}, 32'd1);
    step();
    rst = 1'b0;
    step();
    chk("abort mem_en c3", {31'b0, bus.mem_en}, 32'd0);
    chk("abort ready c3", {30'b0, bus.if_ready, bus.dm_ready}, 32'd0);
    chk("abort dm_rdata", bus.dm_rdata, 32'd0);
    rst = 1'b1;
    bus.dm_req = 1'b0;
    step();
    chk("abort ready c4", {30'b0, bus.if_ready, bus.dm_ready}, 32'd0);
    last_grant = ID_IF;
    run_vec(7, vecs[0]);

    // Latency sweep on the MEM_LAT=1 and MEM_LAT=4 instances.
    for (int k = 0; k < 2; k++) begin
      int          got;
      logic [31:0] d;
      got = -1;
      d = 'x;
      sw_req[k] = 1'b1;
      for (int c = 1; c <= 12 && got < 0; c++) begin
        step();
        if (k == 0 ? bus1.if_ready : bus4.if_ready) begin
          got = c;
          d = (k == 0) ? bus1.if_rdata : bus4.if_rdata;
        end
      end
      step();
      sw_req[k] = 1'b0;
      chk($sformatf("sweep%0d ready cycle", k), got, (k == 0) ? 2 : 5);
      chk($sformatf("sweep%0d rdata", k), d, (k == 0) ? 32'h11110001 : 32'h44440004);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500000, expected finish");
    $fatal(1);
  end

endmodule
